// File: rtl/sharpen_clamp_framer.sv
// Saturates signed sharpened pixels to 8 bits, tags frame geometry
// (sof/eol/eof) and buffers them in a small FIFO for the sink.
//
// Ports:
//   clk, rst         rising-edge clock, async active-high reset
//   in_pixel, in_en  signed pixel from upstream; no backpressure
//   out_pixel        clamped pixel at FIFO head (0 when empty)
//   out_valid        FIFO not empty
//   out_ready        sink accepts head (pop on valid && ready)
//   out_sof/eol/eof  geometry flags of the head pixel
//   overflow         sticky, a pixel was dropped on a full FIFO
// Optional (macro CLIP_COUNT_EN):
//   clip_count       clamped pixels so far in the current frame
//   clip_count_last  total of the previous complete frame
module sharpen_clamp_framer #(
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int IN_W       = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] in_pixel,
  input  logic            in_en,
  output logic [7:0]      out_pixel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_sof,
  output logic            out_eol,
  output logic            out_eof,
  output logic            overflow
`ifdef CLIP_COUNT_EN
  ,
  output logic [15:0]     clip_count,
  output logic [15:0]     clip_count_last
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic signed [IN_W-1:0] MAXV = IN_W'(255);

  typedef struct packed {
    logic [7:0] px;
    logic       sof;
    logic       eol;
    logic       eof;
  } ent_t;

  logic signed [IN_W-1:0] spx;
  logic                   is_neg;
  logic                   is_big;
  logic [7:0]             clamped;

  assign spx    = $signed(in_pixel);
  assign is_neg = spx[IN_W-1];
  assign is_big = spx > MAXV;

  always_comb begin
    clamped = 8'd0;
    unique case (1'b1)
      is_neg:  clamped = 8'd0;
      is_big:  clamped = 8'hFF;
      default: clamped = in_pixel[7:0];
    endcase
  end

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          at_sof;
  logic          at_eol;
  logic          at_eof;

  assign at_sof = (col == '0) && (row == '0);
  assign at_eol = (col == COL_LAST);
  assign at_eof = at_eol && (row == ROW_LAST);

  // Counters track every accepted pixel, even ones the FIFO
  // later drops, so the geometry never slips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (in_en) begin
      if (at_eol) begin
        col <= '0;
        row <= at_eof ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  ent_t s1;
  logic s1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      s1_valid <= in_en;
      if (in_en) begin
        s1 <= '{clamped, at_sof, at_eol, at_eof};
      end
    end
  end

  ent_t          mem [FIFO_DEPTH];
  ent_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          pop;
  logic          push;

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop frees the slot this edge, so a full FIFO still accepts.
  assign push      = s1_valid && (!full || pop);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + (PW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PW+1)'(1);
      end
      if (s1_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  assign out_pixel = out_valid ? head.px  : 8'd0;
  assign out_sof   = out_valid ? head.sof : 1'b0;
  assign out_eol   = out_valid ? head.eol : 1'b0;
  assign out_eof   = out_valid ? head.eof : 1'b0;

`ifdef CLIP_COUNT_EN
  logic clip;

  assign clip = is_neg | is_big;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_count      <= 16'd0;
      clip_count_last <= 16'd0;
    end else if (in_en) begin
      if (at_eof) begin
        clip_count_last <= clip_count + 16'(clip);
        clip_count      <= 16'd0;
      end else if (clip) begin
        clip_count <= clip_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sharpen_clamp_framer.sv
// Randomised and directed bench for sharpen_clamp_framer with a
// queue-based reference model checked on every cycle.
module tb_sharpen_clamp_framer;

  localparam int W = 128;
  localparam int H = 128;
  localparam int N = W * H;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] in_pixel = '0;
  logic       in_en = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       out_sof;
  logic       out_eol;
  logic       out_eof;
  logic       overflow;
`ifdef CLIP_COUNT_EN
  logic [15:0] clip_count;
  logic [15:0] clip_count_last;
`endif

  sharpen_clamp_framer #(
    .IMG_W(W), .IMG_H(H), .IN_W(10), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .in_pixel(in_pixel), .in_en(in_en),
    .out_pixel(out_pixel), .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .overflow(overflow)
`ifdef CLIP_COUNT_EN
    , .clip_count(clip_count),
    .clip_count_last(clip_count_last)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int px;
    bit sof;
    bit eol;
    bit eof;
  } ent_t;

  ent_t q[$];
  ent_t lg[$];
  bit   s1v;
  ent_t s1;
  int   idx;
  bit   ovf;
  int   clipc;
  int   clipl;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc_n = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    s1v = 0;
    s1 = '{0, 0, 0, 0};
    idx = 0;
    ovf = 0;
    clipc = 0;
    clipl = 0;
  endtask

  // Pixel index within the frame drives the flags directly.
  task automatic model_step();
    int v;
    bit pop;
    if (rst) begin
      model_clear();
      return;
    end
    pop = (q.size() != 0) && out_ready;
    if (pop) void'(q.pop_front());
    if (s1v) begin
      if (q.size() < D) q.push_back(s1);
      else ovf = 1;
    end
    s1v = in_en;
    if (in_en) begin
      v = $signed(in_pixel);
      s1.px  = (v < 0) ? 0 : (v > 255) ? 255 : v;
      s1.sof = (idx == 0);
      s1.eol = (idx % W) == W - 1;
      s1.eof = (idx == N - 1);
      if (v < 0 || v > 255) clipc++;
      if (s1.eof) begin
        clipl = clipc;
        clipc = 0;
      end
      idx = (idx + 1) % N;
    end
  endtask

  task automatic cmp();
    logic [12:0] e;
    logic [12:0] g;
    e = '0;
    if (q.size() != 0)
      e = {1'b1, 8'(q[0].px), q[0].sof, q[0].eol, q[0].eof, ovf};
    else
      e[0] = ovf;
    g = {out_valid, out_pixel, out_sof, out_eol, out_eof, overflow};
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL model cyc %0d: got %h expected %h", cyc_n, g, e);
    end
`ifdef CLIP_COUNT_EN
    n_chk++;
    if (clip_count !== 16'(clipc) || clip_count_last !== 16'(clipl)) begin
      n_fail++;
      $display("FAIL clip cyc %0d: got %0d/%0d expected %0d/%0d",
               cyc_n, clip_count, clip_count_last, clipc, clipl);
    end
`endif
  endtask

  // Drive at negedge, log the pop taken at the next posedge,
  // step the model on that edge, compare at the following negedge.
  task automatic cyc(input bit en, input int px, input bit rdy);
    in_en = en;
    in_pixel = 10'(px);
    out_ready = rdy;
    if (out_valid && out_ready)
      lg.push_back('{int'(out_pixel), out_sof, out_eol, out_eof});
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc_n++;
    cmp();
  endtask

  task automatic rpulse(input string nm);
    #2 rst = 1'b1;
    #1;
    chk({nm, "_valid"}, int'(out_valid), 0);
    chk({nm, "_pixel"}, int'(out_pixel), 0);
    chk({nm, "_flags"}, int'({out_sof, out_eol, out_eof}), 0);
    chk({nm, "_ovf"}, int'(overflow), 0);
    model_clear();
    #1 rst = 1'b0;
  endtask

  int vals[7] = '{-5, 0, 128, 255, 256, 511, -512};
  int exps[7] = '{0, 0, 128, 255, 255, 255, 0};
  int cpos[7] = '{5, 100, 2000, 5000, 9000, 12000, 16383};

  initial begin
    int base;
    int v;
    int ns;
    int nl;
    int nf;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_pixel", int'(out_pixel), 0);
    chk("rst_flags", int'({out_sof, out_eol, out_eof}), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst = 1'b0;
    model_clear();

    cyc(1, 200, 1);
    chk("lat_edge1_valid", int'(out_valid), 0);
    cyc(0, 0, 1);
    chk("lat_edge2_valid", int'(out_valid), 1);
    chk("lat_edge2_pixel", int'(out_pixel), 200);
    chk("lat_edge2_sof", int'(out_sof), 1);
    cyc(0, 0, 1);

    base = lg.size();
    for (int i = 0; i < 7; i++) cyc(1, vals[i], 1);
    repeat (4) cyc(0, 0, 1);
    chk("clamp_count", lg.size() - base, 7);
    for (int i = 0; i < 7; i++)
      if (base + i < lg.size())
        chk($sformatf("clamp_%0d", vals[i]), lg[base+i].px, exps[i]);

    for (int i = 0; i < 4; i++) cyc(1, 10 * (i + 1), 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_head", int'(out_pixel), 10);
    chk("bp_ovf0", int'(overflow), 0);
    cyc(1, 50, 0);
    cyc(0, 0, 0);
    chk("bp_ovf1", int'(overflow), 1);
    chk("bp_head2", int'(out_pixel), 10);
    base = lg.size();
    repeat (6) cyc(0, 0, 1);
    chk("bp_drain_n", lg.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < lg.size())
        chk($sformatf("bp_drain_%0d", i), lg[base+i].px, 10 * (i + 1));
    chk("bp_ovf_sticky", int'(overflow), 1);
    rpulse("rst_ovf_clear");

    base = lg.size();
    for (int i = 0; i < 5; i++) cyc(1, 60 + i, 0);
    for (int i = 0; i < 10; i++) cyc(1, 65 + i, 1);
    chk("full_pp_ovf", int'(overflow), 0);
    repeat (6) cyc(0, 0, 1);
    chk("full_pp_n", lg.size() - base, 15);
    for (int i = 0; i < 15; i++)
      if (base + i < lg.size())
        chk($sformatf("full_pp_%0d", i), lg[base+i].px, 60 + i);

    rpulse("rst_frame");
    base = lg.size();
    for (int i = 0; i <= N; i++) begin
      v = $urandom_range(0, 255);
      for (int k = 0; k < 7; k++)
        if (cpos[k] == i) v = (k % 2) ? 300 : -7;
      cyc(1, v, 1);
    end
`ifdef CLIP_COUNT_EN
    chk("clip_last", int'(clip_count_last), 7);
    chk("clip_restart", int'(clip_count), 0);
`endif
    repeat (4) cyc(0, 0, 1);
    chk("frame_n", lg.size() - base, N + 1);
    chk("frame_ovf", int'(overflow), 0);
    ns = 0;
    nl = 0;
    nf = 0;
    for (int j = base; j < lg.size(); j++) begin
      ns += lg[j].sof;
      nl += lg[j].eol;
      nf += lg[j].eof;
    end
    chk("frame_sof_n", ns, 2);
    chk("frame_eol_n", nl, H);
    chk("frame_eof_n", nf, 1);
    if (lg.size() - base == N + 1) begin
      chk("frame_sof_first", int'(lg[base].sof), 1);
      chk("frame_eol_128", int'(lg[base+127].eol), 1);
      chk("frame_eol_16384", int'(lg[base+N-1].eol), 1);
      chk("frame_eof_last", int'(lg[base+N-1].eof), 1);
      chk("frame2_sof", int'(lg[base+N].sof), 1);
    end

    rpulse("rst_pre");
    for (int i = 0; i < 300; i++)
      cyc(1, $urandom_range(0, 1023), i < 296);
    chk("mid_valid", int'(out_valid), 1);
    rpulse("rst_mid");
    cyc(1, 77, 1);
    cyc(0, 0, 1);
    chk("mid_sof", int'(out_sof), 1);
    chk("mid_pixel", int'(out_pixel), 77);

    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1023),
          $urandom_range(0, 9) < 7);
    repeat (6) cyc(0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sharpen_clamp_framer.md
Name: sharpen_clamp_framer

Overview:
- Downstream consumer of the image sharpening stage.
- Takes the signed 10-bit sharpened pixel stream qualified by the upstream enable, saturates each value to unsigned 8-bit, and tags it with frame geometry flags (start of frame, end of line, end of frame).
- A small FIFO lets the write-back/display sink apply backpressure. The upstream stage cannot stall, so lost pixels are flagged.

Parameters:
- IMG_W, 128, pixels per line.
- IMG_H, 128, lines per frame (IMG_W*IMG_H = 16384 pixels per frame).
- IN_W, 10, signed input pixel width.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_pixel  input  IN_W  signed sharpened pixel (two's complement).
- in_en  input  1  in_pixel valid this cycle; no ready back to upstream.
- out_pixel  output  8  clamped unsigned pixel at the FIFO head.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  sink accepts the head; a pop occurs when out_valid && out_ready.
- out_sof  output  1  head is pixel (0,0).
- out_eol  output  1  head is the last column of its line.
- out_eof  output  1  head is the last pixel of the frame.
- overflow  output  1  sticky: a pixel was dropped because the FIFO was full.

Behaviour:
- Reset (async, active-high) forces the following, regardless of state:
  - out_valid=0, out_pixel=0, out_sof/out_eol/out_eof=0, overflow=0.
  - Column and row counters =0, FIFO empty, pipeline valid=0.
  - Deasserting rst mid-frame starts a fresh frame at (0,0). Nothing survives from before the reset.
- Stage 1 (clamp register), on a clk edge with in_en=1:
  - in_pixel < 0 -> 0.
  - in_pixel > 255 -> 255.
  - Otherwise -> in_pixel[7:0].
  - The clamped value and flags sof=(col==0&&row==0), eol=(col==IMG_W-1), eof=(eol&&row==IMG_H-1) are registered together with s1_valid=1.
  - With in_en=0, s1_valid=0 on that edge.
- Geometry counters advance on every in_en, including pixels later dropped, so frame alignment is never lost:
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_W-1, IMG_H-1) both wrap to 0.
- Stage 2 (FIFO write): s1_valid pushes the 11-bit entry {pixel, sof, eol, eof}.
- Latency: a pixel sampled at edge k is visible at the outputs after edge k+1 (out_valid=1) if the FIFO was empty. Sustained throughput is 1 pixel/clk.
- FIFO behaviour:
  - Circular buffer with read/write pointers plus an occupancy count of 0..FIFO_DEPTH.
  - Outputs are driven combinationally from the head entry. When empty, out_valid=0 and out_pixel and the flags read 0.
  - Push and pop in the same cycle: allowed at any occupancy, including full; occupancy is unchanged and no drop occurs.
  - Push when full without a pop: entry discarded, pointers unchanged, overflow set to 1 and held until reset.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Arithmetic: the comparison is signed over IN_W bits. Values from -512 to +511 are all legal input.

Optional Feature:
- Macro: CLIP_COUNT_EN.
- When defined:
  - Extra output clip_count [15:0] counts pixels clamped (value <0 or >255) in the current frame. The count is taken at stage 1, including pixels later dropped.
  - On the clamp of the eof pixel, clip_count_last [15:0] latches the frame total including that pixel, and clip_count resets to 0.
  - Both outputs are 0 on reset.
- When not defined: neither port exists, and no counter logic is present.

Test Plan:
- Clamp values: apply in_pixel = -5, 0, 128, 255, 256, 511, -512, with out_ready=1 -> out_pixel = 0, 0, 128, 255, 255, 255, 0, each appearing 2 edges after its input.
- Full frame: stream 16384 pixels back-to-back, out_ready=1 -> out_sof only on the 1st output, out_eol on outputs 128, 256, ..., out_eof only on the 16384th, overflow stays 0. A second frame's first output has out_sof=1.
- Backpressure: out_ready=0, push 4 pixels -> out_valid=1 and the head stays the first pixel. A 5th push -> overflow=1 and the entry is dropped. Then out_ready=1 drains exactly the 4 original pixels in order.
- Full plus simultaneous push/pop: with the FIFO full, hold out_ready=1 and in_en=1 for 10 cycles -> no overflow, and outputs remain in order.
- Async reset mid-frame: after 300 pixels, pulse rst between edges -> outputs clear immediately. The next pixel after release carries out_sof=1.
- CLIP_COUNT_EN: a frame containing 7 out-of-range values -> clip_count_last=7 after eof, and clip_count restarts at 0.
